// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// active-low segment codes and the digit buffer entry layout.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] value;
    logic       dp;
    logic       blank;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-7-segment decoder producing active-low {g..a} patterns.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[value];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with digit buffer, PWM brightness,
// blink, blanking, decimal point, leading-zero suppression and per-slot dead time.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SUB_DIV      = 1250,
  parameter int PWM_BITS     = 3,
  parameter int BLINK_FRAMES = 64,
  localparam int AW          = $clog2(N_DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [3:0]          wdata,
  input  logic                wdp,
  input  logic                wblank,
  input  logic [PWM_BITS-1:0] bright,
  input  logic [N_DIGITS-1:0] blink_en,
  input  logic                lz_en,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic                frame_tick
);

  localparam int PRE_W = $clog2(SUB_DIV);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(SUB_DIV - 1);
  localparam logic [PWM_BITS-1:0] SUB_MAX = '1;
  localparam logic [AW-1:0]       DIG_MAX = AW'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0]    BLK_MAX = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE  = N_DIGITS'(1);

  entry_t                dbuf_reg [N_DIGITS];
  logic [PRE_W-1:0]      pre_reg;
  logic [PWM_BITS-1:0]   sub_reg;
  logic [PWM_BITS-1:0]   bright_q;
  logic [AW-1:0]         dig_reg;
  logic [BLK_W-1:0]      blink_cnt_reg;
  logic                  blink_phase_reg;
  logic                  wrap_reg;
  logic [N_DIGITS-1:0]   an_reg;
  logic [6:0]            seg_reg;
  logic                  dp_reg;
  logic                  frame_tick_reg;

  logic                  slot_start;
  logic                  pre_wrap;
  logic                  sub_wrap;
  logic                  frame_wrap;
  logic                  lit;
  logic [N_DIGITS-1:0]   zero_d;
  logic [N_DIGITS-1:0]   lz_sup;
  entry_t                cur;
  logic [6:0]            cur_seg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        dbuf_reg[i] <= entry_t'({ENTRY_W{1'b0}});
      end
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (we && (waddr == AW'(i))) begin
          dbuf_reg[i] <= '{value: wdata, dp: wdp, blank: wblank};
        end
      end
    end
  end

  assign slot_start = (pre_reg == '0) && (sub_reg == '0);
  assign pre_wrap   = (pre_reg == PRE_MAX);
  assign sub_wrap   = pre_wrap && (sub_reg == SUB_MAX);
  assign frame_wrap = sub_wrap && (dig_reg == DIG_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_reg         <= '0;
      sub_reg         <= '0;
      dig_reg         <= '0;
      bright_q        <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      wrap_reg        <= 1'b0;
    end else begin
      pre_reg <= pre_wrap ? '0 : pre_reg + 1'b1;
      if (pre_wrap) begin
        sub_reg <= sub_reg + 1'b1;
      end
      if (sub_wrap) begin
        dig_reg <= (dig_reg == DIG_MAX) ? '0 : dig_reg + 1'b1;
      end
      if (slot_start) begin
        bright_q <= bright;
      end
      if (frame_wrap) begin
        if (blink_cnt_reg == BLK_MAX) begin
          blink_cnt_reg   <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
      end
      wrap_reg <= frame_wrap;
    end
  end

  // A digit is a "leading zero" when it and every more-significant digit shows nothing.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_lz
      assign zero_d[gi] = dbuf_reg[gi].blank ||
                          ((dbuf_reg[gi].value == 4'h0) && !dbuf_reg[gi].dp);
      if (gi == 0) begin : g_first
        assign lz_sup[gi] = 1'b0;
      end else begin : g_rest
        assign lz_sup[gi] = lz_en && (&zero_d[N_DIGITS-1:gi]);
      end
    end
  endgenerate

  assign cur = dbuf_reg[dig_reg];

  seg_hex_decoder u_dec (
    .value (cur.value),
    .seg   (cur_seg)
  );

  assign lit = (sub_reg <= bright_q) && !slot_start && !cur.blank &&
               !(blink_en[dig_reg] && blink_phase_reg) && !lz_sup[dig_reg];

  always_ff @(posedge clk) begin
    if (!rst) begin
      an_reg         <= '1;
      seg_reg        <= SEG_OFF;
      dp_reg         <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= wrap_reg;
      if (lit) begin
        an_reg  <= ~(AN_ONE << dig_reg);
        seg_reg <= cur_seg;
        dp_reg  <= ~cur.dp;
      end else begin
        an_reg  <= '1;
        seg_reg <= SEG_OFF;
        dp_reg  <= 1'b1;
      end
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, slot 16 cycles, frame 64 cycles):
// per-cycle reference model plus table-driven and hand-written corner sequences.
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [1:0] waddr;
  logic [3:0] wdata;
  logic       wdp;
  logic       wblank;
  logic [1:0] bright;
  logic [3:0] blink_en;
  logic       lz_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(
    .N_DIGITS(4), .SUB_DIV(4), .PWM_BITS(2), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wdp(wdp),
    .wblank(wblank), .bright(bright), .blink_en(blink_en), .lz_en(lz_en),
    .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: scan position counted in cycles since reset
  int         pos;
  int         bq;
  logic [3:0] mval [4];
  logic [3:0] mdp;
  logic [3:0] mbl;

  int         lit_cnt [4];
  logic [6:0] seg_seen [4];
  int         ft_cnt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic bit shows_nothing(input int j);
    return mbl[j] || ((mval[j] == 4'h0) && !mdp[j]);
  endfunction

  task automatic model_out(output logic [3:0] e_an, output logic [6:0] e_seg,
                           output logic e_dp, output logic e_ft);
    int p, pre, sub, dig;
    bit lit, phase, sup;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    if (rst) begin
      p     = pos % 64;
      pre   = p % 4;
      sub   = (p / 4) % 4;
      dig   = p / 16;
      phase = ((pos / 128) % 2) == 1;
      sup   = 1'b0;
      if (lz_en && dig > 0) begin
        sup = 1'b1;
        for (int j = dig; j < 4; j++) if (!shows_nothing(j)) sup = 1'b0;
      end
      lit = (sub <= bq) && !(pre == 0 && sub == 0) && !mbl[dig] &&
            !(blink_en[dig] && phase) && !sup;
      if (lit) begin
        e_an  = ~(4'b0001 << dig);
        e_seg = hex7(mval[dig]);
        e_dp  = ~mdp[dig];
      end
      e_ft = (pos > 0) && (pos % 64 == 0);
    end
  endtask

  task automatic model_update();
    if (!rst) begin
      pos = 0; bq = 0; mdp = '0; mbl = '0;
      for (int j = 0; j < 4; j++) mval[j] = 4'h0;
    end else begin
      if (pos % 16 == 0) bq = int'(bright);
      if (we) begin
        mval[waddr] = wdata; mdp[waddr] = wdp; mbl[waddr] = wblank;
      end
      pos++;
    end
  endtask

  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_ft;
    model_out(e_an, e_seg, e_dp, e_ft);
    @(posedge clk);
    model_update();
    #1;
    checks++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_tick !== e_ft) begin
      errors++;
      $display("FAIL cycle t=%0t: an=%b seg=%h dp=%b ft=%b, required an=%b seg=%h dp=%b ft=%b",
               $time, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic write_digit(input int d, input logic [3:0] v, input logic p, input logic b);
    we = 1'b1; waddr = 2'(d); wdata = v; wdp = p; wblank = b;
    step();
    we = 1'b0; wdp = 1'b0; wblank = 1'b0;
  endtask

  task automatic sync_frame();
    bit found = 1'b0;
    for (int i = 0; i < 130 && !found; i++) begin
      step();
      if (frame_tick) found = 1'b1;
    end
    check("sync_frame_tick_seen", int'(found), 1);
  endtask

  task automatic run_frame();
    ft_cnt = 0;
    for (int d = 0; d < 4; d++) begin lit_cnt[d] = 0; seg_seen[d] = 7'h7F; end
    for (int i = 0; i < 64; i++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        if (an[d] == 1'b0) begin lit_cnt[d]++; seg_seen[d] = seg; end
      end
      if (frame_tick) ft_cnt++;
    end
  endtask

  typedef struct {
    logic [15:0] vals;
    logic [3:0]  dps;
    logic [3:0]  blanks;
    logic        lz;
    logic [3:0]  exp_mask;
  } lz_vec_t;

  lz_vec_t lzt [9];
  int      bexp [6];

  initial begin
    lzt[0] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 4'b0011};
    lzt[1] = '{16'h0050, 4'b0100, 4'b0000, 1'b1, 4'b0111};
    lzt[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 4'b0001};
    lzt[3] = '{16'h0000, 4'b0000, 4'b0000, 1'b0, 4'b1111};
    lzt[4] = '{16'h1000, 4'b0000, 4'b0000, 1'b1, 4'b1111};
    lzt[5] = '{16'h7040, 4'b0000, 4'b1000, 1'b1, 4'b0011};
    lzt[6] = '{16'h0200, 4'b0000, 4'b0100, 1'b1, 4'b0001};
    lzt[7] = '{16'h0000, 4'b0001, 4'b0000, 1'b1, 4'b0001};
    lzt[8] = '{16'h0000, 4'b1000, 4'b0000, 1'b1, 4'b1111};
    bexp   = '{15, 15, 0, 0, 15, 15};

    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wdp = 1'b0; wblank = 1'b0;
    bright = 2'd3; blink_en = 4'b0000; lz_en = 1'b0;
    pos = 0; bq = 0; mdp = '0; mbl = '0;
    for (int j = 0; j < 4; j++) mval[j] = 4'h0;

    // Reset and first lit cycle
    repeat (3) step();
    check("reset_an", int'(an), 'hF);
    check("reset_seg", int'(seg), 'h7F);
    check("reset_dp", int'(dp), 1);
    check("reset_ft", int'(frame_tick), 0);
    rst = 1'b1;
    step();
    check("dead_cycle_an", int'(an), 'hF);
    step();
    check("first_an", int'(an), 'hE);
    check("first_seg", int'(seg), 'h40);
    $display("reset sequence done");

    // Brightness duty per slot
    for (int d = 0; d < 4; d++) write_digit(d, 4'(d + 1), 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      bright = 2'(b);
      sync_frame();
      run_frame();
      run_frame();
      for (int d = 0; d < 4; d++) check($sformatf("bright%0d_lit_d%0d", b, d), lit_cnt[d], 4 * b + 3);
      check($sformatf("bright%0d_ft_per_frame", b), ft_cnt, 1);
      $display("bright=%0d: lit cycles %0d %0d %0d %0d", b, lit_cnt[0], lit_cnt[1], lit_cnt[2], lit_cnt[3]);
    end
    check("digit3_seg", int'(seg_seen[3]), 'h19);
    check("digit0_seg", int'(seg_seen[0]), 'h79);
    check("frame_end_tick", int'(frame_tick), 1);

    // Leading-zero suppression and blanking table
    bright = 2'd3;
    for (int v = 0; v < 9; v++) begin
      logic [3:0] mask;
      lz_en = 1'b0;
      for (int d = 0; d < 4; d++)
        write_digit(d, lzt[v].vals[d*4 +: 4], lzt[v].dps[d], lzt[v].blanks[d]);
      lz_en = lzt[v].lz;
      sync_frame();
      run_frame();
      run_frame();
      for (int d = 0; d < 4; d++) mask[d] = (lit_cnt[d] > 0);
      check($sformatf("lz_vec%0d_mask", v), int'(mask), int'(lzt[v].exp_mask));
      $display("lz vec %0d: lit mask %b", v, mask);
    end

    // Write to the displayed digit in the middle of its slot
    lz_en = 1'b0;
    for (int d = 0; d < 4; d++) write_digit(d, 4'(d + 1), 1'b0, 1'b0);
    sync_frame();
    repeat (4) step();
    we = 1'b1; waddr = 2'd0; wdata = 4'hA; wdp = 1'b1; wblank = 1'b0;
    step();
    check("midslot_old_seg", int'(seg), 'h79);
    we = 1'b0; wdp = 1'b0;
    step();
    check("midslot_new_seg", int'(seg), 'h08);
    check("midslot_new_dp", int'(dp), 0);
    check("midslot_new_an", int'(an), 'hE);
    $display("mid-slot write done");

    // Reset mid-slot drops a concurrent write
    repeat (3) step();
    rst = 1'b0; we = 1'b1; waddr = 2'd0; wdata = 4'h9; wdp = 1'b0;
    step();
    check("midrst_an", int'(an), 'hF);
    check("midrst_seg", int'(seg), 'h7F);
    check("midrst_dp", int'(dp), 1);
    check("midrst_ft", int'(frame_tick), 0);
    rst = 1'b1; we = 1'b0;
    step();
    step();
    check("midrst_write_dropped_seg", int'(seg), 'h40);
    check("midrst_write_dropped_an", int'(an), 'hE);
    $display("mid-slot reset done");

    // Blink: digit 0 dark in frames 2-3, lit in 0-1 and 4-5
    rst = 1'b0;
    step();
    rst = 1'b1; blink_en = 4'b0001; bright = 2'd3;
    for (int f = 0; f < 6; f++) begin
      run_frame();
      check($sformatf("blink_frame%0d_d0", f), lit_cnt[0], bexp[f]);
      check($sformatf("blink_frame%0d_d1", f), lit_cnt[1], 15);
      $display("blink frame %0d: digit0 lit %0d", f, lit_cnt[0]);
    end
    blink_en = 4'b0000;

    // Random traffic against the reference model
    for (int i = 0; i < 2500; i++) begin
      we     = ($urandom_range(0, 3) == 0);
      waddr  = 2'($urandom_range(0, 3));
      wdata  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      wdp    = ($urandom_range(0, 3) == 0);
      wblank = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 40) == 0) bright = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 100) == 0) blink_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 150) == 0) lz_en = ~lz_en;
      rst = ($urandom_range(0, 499) != 0);
      step();
    end
    $display("random phase done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
